conv1d_loop_counter: RTL
========================

Name: conv1d_loop_counter

Overview:
- Parametrised two-level nested loop counter for the conv1d core. Successor to the single free-running N-bit counter with a fixed all-ones terminal count.
- Adds run-time programmable limits, start/stop control, a stall input, one-shot or continuous mode, and per-level terminal-count pulses.
- Drives the kernel-tap index (inner loop) and the output-sample index (outer loop) for the MAC datapath and buffer address generation.

Parameters:
N_INNER, 4, width of the inner (tap) counter and its limit
N_OUTER, 8, width of the outer (sample) counter and its limit

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled in IDLE only
stop  input  1  abort a run; sampled in RUN only
enable  input  1  advance permission; 0 stalls the counters
continuous  input  1  latched at start; 1 = restart automatically after the final iteration
inner_max  input  N_INNER  inner terminal value; latched at start
outer_max  input  N_OUTER  outer terminal value; latched at start
inner_count  output  N_INNER  current inner index
outer_count  output  N_OUTER  current outer index
inner_tc  output  1  registered pulse: the inner counter wrapped on the previous edge
outer_tc  output  1  registered pulse: the outer counter wrapped on the previous edge
last  output  1  combinational: busy and inner_count==inner_lim and outer_count==outer_lim
busy  output  1  high while in RUN
done  output  1  registered one-cycle pulse at completion of a one-shot run

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset: state=IDLE; inner_count, outer_count, latched limits and latched mode all 0; inner_tc, outer_tc, busy and done all 0. Reset has priority over every other input.
- States: IDLE and RUN.
- IDLE, start=1: latch inner_max into inner_lim, outer_max into outer_lim, continuous into cont_q. Clear both counts. Next state is RUN. busy=1 from the next cycle.
- IDLE, other inputs: stop and enable are ignored and counts hold at 0.
- RUN priority order is stop, then enable.
- RUN, stop=1: next state IDLE; counts cleared; inner_tc, outer_tc and done all 0 next cycle, even if enable=1 and last=1 in the same cycle.
- RUN, enable=0: counts hold; inner_tc and outer_tc are 0 next cycle. A pulse occurs only on an advancing edge.
- RUN, enable=1 and inner_count<inner_lim: inner_count+1; inner_tc=0.
- RUN, enable=1 and inner_count==inner_lim: inner_count set to 0; inner_tc=1. Then:
  - outer_count<outer_lim: outer_count+1; outer_tc=0.
  - outer_count==outer_lim: outer_count set to 0; outer_tc=1.
    - cont_q=1: stay in RUN; done=0.
    - cont_q=0: go to IDLE; done=1; busy=0 in that same next cycle.
- start in RUN is ignored. Limits and mode cannot change mid-run.
- Pulse timing: inner_tc, outer_tc and done are registered. They assert in the cycle where the counts already show their wrapped value of 0.
- Limit 0 is legal:
  - inner_lim=0: inner wraps on every enabled cycle.
  - inner_lim=0 and outer_lim=0: a one-shot run completes on the first enabled cycle.
- Run length: enabled cycles per pass = (inner_lim+1)*(outer_lim+1).
- Wrap arithmetic: counts never exceed their latched limit. With limits at all-ones, wrap is natural modulo 2^N.
- last: purely combinational from state and registers. No input-to-output path.
- Reset asserted mid-run: everything returns to reset values on that edge. No done pulse.

Test Plan:
- Reset during RUN with counts 3/5 -> next cycle all outputs 0, busy=0, done=0.
- inner_max=2, outer_max=1, continuous=0, start, enable held high -> inner sequence 0,1,2,0,1,2; outer 0,0,0,1,1,1; inner_tc high 2 cycles; done and outer_tc high exactly once, on the 6th advance; busy falls on that same cycle.
- Same config with enable toggling 1,0 -> identical sequence over 12 cycles; no tc pulse on stalled cycles; last held high while stalled on the final iteration.
- inner_max=0, outer_max=0, one-shot -> done on the first enabled cycle. Then continuous=1 with limits 1/1 -> outer_tc every 4 enabled cycles, busy stays 1, done never asserts.
- Stop at counts 1/1 with enable=1 and last=1 -> IDLE; counts 0; no done, no tc pulse.
- start while busy with new limits 7/7 -> ignored; the run completes with the original limits. start and reset in the same cycle -> remains IDLE.

Source files
------------

// File: rtl/conv1d_loop_counter.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_loop_counter
// Purpose  : Two-level nested loop counter for the conv1d core. The inner
//            loop walks the kernel taps, the outer loop walks output samples.
//            Limits and the one-shot/continuous mode are captured at start and
//            stay fixed for the whole run.
// Ports    : clk         - clock, rising edge
//            reset       - synchronous active-high reset
//            start       - begin a run (honoured in IDLE only)
//            stop        - abort a run (honoured in RUN only)
//            enable      - advance permission, 0 stalls the counters
//            continuous  - captured at start, 1 = restart after final pass
//            inner_max   - inner terminal value, captured at start
//            outer_max   - outer terminal value, captured at start
//            inner_count - current tap index
//            outer_count - current sample index
//            inner_tc    - pulse: inner counter wrapped on the previous edge
//            outer_tc    - pulse: outer counter wrapped on the previous edge
//            last        - in RUN and both counts sit at their limits
//            busy        - high while in RUN
//            done        - pulse: a one-shot run has just completed
// Revision : 1.0 - initial release
// ============================================================================
module conv1d_loop_counter #(
   parameter int N_INNER = 4,
   parameter int N_OUTER = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               enable,
   input  logic               continuous,
   input  logic [N_INNER-1:0] inner_max,
   input  logic [N_OUTER-1:0] outer_max,
   output logic [N_INNER-1:0] inner_count,
   output logic [N_OUTER-1:0] outer_count,
   output logic               inner_tc,
   output logic               outer_tc,
   output logic               last,
   output logic               busy,
   output logic               done
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [N_INNER-1:0] C_INNER_ONE = {{(N_INNER-1){1'b0}}, 1'b1};
   localparam logic [N_OUTER-1:0] C_OUTER_ONE = {{(N_OUTER-1){1'b0}}, 1'b1};

   logic [0:0]         r_state;
   logic [N_INNER-1:0] r_inner;
   logic [N_OUTER-1:0] r_outer;
   logic [N_INNER-1:0] r_inner_lim;
   logic [N_OUTER-1:0] r_outer_lim;
   logic               r_cont;
   logic               r_inner_tc;
   logic               r_outer_tc;
   logic               r_done;

   logic w_inner_at_lim;
   logic w_outer_at_lim;

   assign w_inner_at_lim = (r_inner == r_inner_lim);
   assign w_outer_at_lim = (r_outer == r_outer_lim);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_inner     <= '0;
         r_outer     <= '0;
         r_inner_lim <= '0;
         r_outer_lim <= '0;
         r_cont      <= 1'b0;
         r_inner_tc  <= 1'b0;
         r_outer_tc  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         // Pulses are one cycle wide; only an advancing edge may raise them.
         r_inner_tc <= 1'b0;
         r_outer_tc <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_inner <= '0;
               r_outer <= '0;
               if (start) begin
                  r_inner_lim <= inner_max;
                  r_outer_lim <= outer_max;
                  r_cont      <= continuous;
                  r_state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (stop) begin
                  // Abort wins even on the final iteration: no pulses.
                  r_inner <= '0;
                  r_outer <= '0;
                  r_state <= S_IDLE;
               end else if (enable) begin
                  if (!w_inner_at_lim) begin
                     r_inner <= r_inner + C_INNER_ONE;
                  end else begin
                     r_inner    <= '0;
                     r_inner_tc <= 1'b1;
                     if (!w_outer_at_lim) begin
                        r_outer <= r_outer + C_OUTER_ONE;
                     end else begin
                        r_outer    <= '0;
                        r_outer_tc <= 1'b1;
                        if (!r_cont) begin
                           r_done  <= 1'b1;
                           r_state <= S_IDLE;
                        end
                     end
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign inner_count = r_inner;
   assign outer_count = r_outer;
   assign inner_tc    = r_inner_tc;
   assign outer_tc    = r_outer_tc;
   assign done        = r_done;
   assign busy        = (r_state == S_RUN);
   // Built only from registers, so no input reaches this output.
   assign last        = busy && w_inner_at_lim && w_outer_at_lim;

endmodule
`default_nettype wire
